// File: rtl/enc_pkg.sv
// Shared types and helpers for the priority encoders: default widths, the encoded-result
// struct and the handshake state type.
package enc_pkg;

  localparam int unsigned EncN   = 4;
  localparam int unsigned EncIw  = 2;
  // Helpers work on a zero-extended vector so any request width up to VecMax can share them.
  localparam int unsigned VecMax = 32;
  localparam int unsigned IdxMax = 5;

  typedef enum logic {StEmpty, StFull} hs_state_e;

  typedef struct packed {
    logic [IdxMax-1:0] idx;
    logic              none;
    logic              multi;
  } enc_res_t;

  function automatic logic [IdxMax-1:0] prio_idx(input logic [VecMax-1:0] vec,
                                                 input logic              msb_prio);
    logic [IdxMax-1:0] idx;
    idx = '0;
    if (msb_prio) begin
      for (int i = 0; i < int'(VecMax); i++) begin
        if (vec[i]) idx = IdxMax'(i);
      end
    end else begin
      for (int i = int'(VecMax) - 1; i >= 0; i--) begin
        if (vec[i]) idx = IdxMax'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic popcount_gt1(input logic [VecMax-1:0] vec);
    return (vec & (vec - VecMax'(1))) != '0;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational N-to-log2(N) priority encoder with enable, none and multi-hot flags.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int unsigned N        = EncN,
  parameter int unsigned IW       = EncIw,
  parameter bit          MSB_PRIO = 1'b1
) (
  input  logic [N-1:0]  in_i,
  input  logic          en_i,
  output logic [IW-1:0] idx_o,
  output logic          none_o,
  output logic          multi_o
);

  logic [VecMax-1:0] vec;
  enc_res_t          res;

  assign vec = VecMax'(in_i);

  always_comb begin
    res = '{idx: '0, none: 1'b1, multi: 1'b0};
    if (en_i && (|in_i)) begin
      res.idx   = prio_idx(vec, MSB_PRIO);
      res.none  = 1'b0;
      res.multi = popcount_gt1(vec);
    end
  end

  assign idx_o   = IW'(res.idx);
  assign none_o  = res.none;
  assign multi_o = res.multi;

endmodule

// File: rtl/encoder_hs.sv
// Registered priority encoder behind a one-entry valid/ready output stage, with a
// saturating count of accepted multi-hot words.
module encoder_hs
  import enc_pkg::*;
#(
  parameter int unsigned N        = EncN,
  parameter int unsigned IW       = EncIw,
  parameter bit          MSB_PRIO = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_i,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [IW-1:0]    out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_none_o,
  output logic             out_multi_o,
  output logic [CNT_W-1:0] err_cnt_o,
  input  logic             clr_cnt_i
);

  hs_state_e        state_q;
  logic [IW-1:0]    out_q;
  logic             none_q, multi_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IW-1:0]    enc_idx;
  logic             enc_none, enc_multi;
  logic             accept, present;

  prio_enc_comb #(
    .N        (N),
    .IW       (IW),
    .MSB_PRIO (MSB_PRIO)
  ) u_prio_enc (
    .in_i    (in_i),
    .en_i    (en_i),
    .idx_o   (enc_idx),
    .none_o  (enc_none),
    .multi_o (enc_multi)
  );

  assign out_valid_o = (state_q == StFull);
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign present     = out_valid_o && out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (accept && enc_multi && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Data registers load only on accept, so an undriven request vector never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      out_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_q <= StFull;
        StFull:  if (present && !accept) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
      if (accept) begin
        out_q   <= enc_idx;
        none_q  <= enc_none;
        multi_q <= enc_multi;
      end
      cnt_q <= cnt_d;
    end
  end

  assign out_o       = out_q;
  assign out_none_o  = none_q;
  assign out_multi_o = multi_q;
  assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_encoder_hs.sv
// Directed bench for encoder_hs: a default instance plus an LSB-priority, 2-bit-counter one.
module tb_encoder_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic       en, in_valid, out_ready, clr_cnt;

  logic       in_ready, out_valid, out_none, out_multi;
  logic [1:0] out;
  logic [7:0] err_cnt;

  logic       a_in_ready, a_out_valid, a_out_none, a_out_multi;
  logic [1:0] a_out;
  logic [1:0] a_err_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  encoder_hs u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_i        (in),
    .en_i        (en),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_o       (out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_none_o  (out_none),
    .out_multi_o (out_multi),
    .err_cnt_o   (err_cnt),
    .clr_cnt_i   (clr_cnt)
  );

  encoder_hs #(
    .MSB_PRIO (1'b0),
    .CNT_W    (2)
  ) u_alt (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_i        (in),
    .en_i        (en),
    .in_valid_i  (in_valid),
    .in_ready_o  (a_in_ready),
    .out_o       (a_out),
    .out_valid_o (a_out_valid),
    .out_ready_i (out_ready),
    .out_none_o  (a_out_none),
    .out_multi_o (a_out_multi),
    .err_cnt_o   (a_err_cnt),
    .clr_cnt_i   (clr_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in = '0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    #3;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out !== 2'd0) $display("FAIL reset_out: got %0d want 0", out); else pass_cnt++;
    total_cnt++; if ({out_none, out_multi} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {out_none, out_multi}); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", err_cnt); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    in = 4'b0100; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    total_cnt++; if (out !== 2'd2) $display("FAIL single_out: got %0d want 2", out); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if ({out_none, out_multi} !== 2'b00) $display("FAIL single_flags: got %b want 00", {out_none, out_multi}); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL single_cnt: got %0d want 0", err_cnt); else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [3:0] vecs [3] = '{4'b0001, 4'b0010, 4'b1000};
    logic [1:0] exps [3] = '{2'd0, 2'd1, 2'd3};
    en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = vecs[i];
      step();
      total_cnt++; if (out !== exps[i] || out_valid !== 1'b1) $display("FAIL stream_out%0d: got %0d/%b want %0d/1", i, out, out_valid, exps[i]); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); else pass_cnt++;
    end
    in_valid = 1'b0; in = 4'bxxxx;
    step();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b want 0", out_valid); else pass_cnt++;
    step();
    total_cnt++; if (out !== 2'd3 || out_none !== 1'b0) $display("FAIL stream_x_hold: got %0d/%b want 3/0", out, out_none); else pass_cnt++;
  endtask

  task automatic test_multi();
    in = 4'b0110; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    total_cnt++; if (out !== 2'd2 || out_multi !== 1'b1) $display("FAIL multi_msb: got %0d/%b want 2/1", out, out_multi); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1) $display("FAIL multi_cnt: got %0d want 1", err_cnt); else pass_cnt++;
    total_cnt++; if (a_out !== 2'd1 || a_out_multi !== 1'b1) $display("FAIL multi_lsb: got %0d/%b want 1/1", a_out, a_out_multi); else pass_cnt++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_none();
    in = 4'b0000; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    total_cnt++; if ({out, out_none, out_multi} !== 4'b0010) $display("FAIL none_zero: got %b want 0010", {out, out_none, out_multi}); else pass_cnt++;
    in = 4'b1111; en = 1'b0;
    step();
    total_cnt++; if ({out, out_none, out_multi} !== 4'b0010) $display("FAIL none_dis: got %b want 0010", {out, out_none, out_multi}); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1) $display("FAIL none_cnt: got %0d want 1", err_cnt); else pass_cnt++;
    in_valid = 1'b0; en = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    in = 4'b1000; en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", i, in_ready); else pass_cnt++;
      total_cnt++; if (out !== 2'd3 || out_valid !== 1'b1) $display("FAIL bp_hold%0d: got %0d/%b want 3/1", i, out, out_valid); else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out !== 2'd0 || out_valid !== 1'b1) $display("FAIL bp_next: got %0d/%b want 0/1", out, out_valid); else pass_cnt++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    in = 4'b0011; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 2 || i == 3 || i == 5) begin
        total_cnt++; if (a_err_cnt !== ((i > 3) ? 2'd3 : 2'(i))) $display("FAIL sat_cnt%0d: got %0d want %0d", i, a_err_cnt, (i > 3) ? 3 : i); else pass_cnt++;
      end
    end
    total_cnt++; if (err_cnt !== 8'd5) $display("FAIL sat_wide: got %0d want 5", err_cnt); else pass_cnt++;
    in = 4'b0101; clr_cnt = 1'b1;
    step();
    total_cnt++; if (a_err_cnt !== 2'd0 || err_cnt !== 8'd0) $display("FAIL sat_clr: got %0d/%0d want 0/0", a_err_cnt, err_cnt); else pass_cnt++;
    clr_cnt = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    in = 4'b0011; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || err_cnt !== 8'd1) $display("FAIL ar_pre: got %b/%0d want 1/1", out_valid, err_cnt); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0 || out !== 2'd0) $display("FAIL ar_regs: got %0d/%0d want 0/0", err_cnt, out); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_multi();
    test_none();
    test_backpressure();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/encoder_hs.md
Name: encoder_hs

Overview:
Registered 4-to-2 priority encoder with valid/ready handshake. It is the inverse of the team's 2-to-4 enable decoder.
- Accepts a one-hot request vector plus enable.
- Emits the binary index, a "none" flag and a "multi-hot" error flag through a one-entry output register.
- Keeps a saturating count of multi-hot errors.
- Sits between request sources and the decoder so encoded indices can be re-decoded downstream.

Parameters:
N, 4, width of request vector (power of 2, ≥2)
IW, 2, index width = log2(N)
MSB_PRIO, 1, 1: highest set bit wins; 0: lowest set bit wins
CNT_W, 8, width of error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in  in  N  request vector
en  in  1  enable; when 0 the word is encoded as "none"
in_valid  in  1  input word present
in_ready  out  1  block can accept a word this cycle
out  out  IW  encoded index
out_valid  out  1  output register holds a word
out_ready  in  1  consumer accepts the output this cycle
out_none  out  1  no bit set, or en=0
out_multi  out  1  more than one bit set with en=1
err_cnt  out  CNT_W  saturating count of accepted multi-hot words
clr_cnt  in  1  synchronous clear of err_cnt

Behaviour:
- Reset (rst_n=0, asynchronous): out=0, out_valid=0, out_none=0, out_multi=0, err_cnt=0.
  - Registers stay in reset while rst_n=0.
  - Release is synchronised by the surrounding design.
- in_ready = !out_valid || out_ready. This is combinational, with no dependency on in_valid.
- Accept = in_valid && in_ready. Present = out_valid && out_ready.
- On accept, the registers load on the next clk edge, so latency is 1 cycle from accept to out_valid=1:
  - en=1, exactly one bit i set: out=i, none=0, multi=0.
  - en=1, zero bits set: out=0, none=1, multi=0.
  - en=1, ≥2 bits set: out = index of the winning bit per MSB_PRIO, none=0, multi=1.
  - en=0: out=0, none=1, multi=0, regardless of `in`.
- Present without accept: out_valid←0. out, out_none and out_multi hold their last values (don't-care to consumer).
- Present and accept in the same cycle: new word loads and out_valid stays 1, giving full throughput of 1 word/cycle.
- out_valid=1 && out_ready=0: all outputs stable, in_ready=0, inputs ignored (backpressure).
- State machine, 2 states:
  - EMPTY (out_valid=0) → FULL on accept.
  - FULL → EMPTY on present without accept.
  - FULL → FULL on present with accept, or on stall.
- err_cnt:
  - +1 on each accept of a multi-hot word.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - clr_cnt has priority over the increment: if both occur in the same cycle, the result is 0.
- Reset mid-transfer: the held word is discarded, out_valid drops immediately (async), and the counter clears.
- X on `in` while in_valid=0 must not propagate to the registers.

Decomposition:
- Shared package enc_pkg:
  - N and IW defaults.
  - Result struct {idx, none, multi}.
  - Function prio_idx(vec, msb_prio).
  - Function popcount_gt1(vec).
- One combinational sub-module, prio_enc_comb (in, en → idx, none, multi), reusable by other encoders.
- The top-level module holds only the handshake register and the counter.

Test Plan:
1. Reset, then in_valid=1, en=1, in=4'b0100, out_ready=1 → next cycle: out=2, out_valid=1, none=0, multi=0, err_cnt=0.
2. Stream in=0001,0010,1000 on consecutive cycles with out_ready=1 → out=0,1,3 on consecutive cycles, in_ready held 1.
3. in=4'b0110, en=1, MSB_PRIO=1 → out=2, multi=1, err_cnt=1. Same stimulus with MSB_PRIO=0 → out=1.
4. in=0000, en=1 → none=1, out=0. Then in=1111, en=0 → none=1, multi=0, err_cnt unchanged.
5. Load in=1000, hold out_ready=0 for 3 cycles while driving in=0001 → in_ready=0 and out=3 stable. Raise out_ready → in=0001 accepted, out=0 the next cycle.
6. With CNT_W=2, drive 5 multi-hot words → err_cnt=3. Then clr_cnt=1 with a multi-hot accept in the same cycle → err_cnt=0. Assert rst_n=0 while out_valid=1 → out_valid=0 without waiting for a clk edge.
